// File: rtl/led_matrix_row_scanner.sv
// Row scan controller for the 7x5 LED matrix: double-buffered frame, one-hot row drive.
// Optional dead time between rows when SCANNER_BLANKING_EN is defined.
module led_matrix_row_scanner #(
    parameter int CLK_DIV      = 50000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [34:0] frame_data,
    input  logic        frame_valid,
    output logic        frame_ready,
    output logic [34:0] rows_values,
    output logic [2:0]  bin_number_sel,
    output logic [4:0]  row_enable,
    output logic        frame_start
);

    localparam int MAXC = (CLK_DIV > BLANK_CYCLES) ? CLK_DIV : BLANK_CYCLES;
    localparam int DW   = (MAXC > 2) ? $clog2(MAXC) : 1;

`ifdef SCANNER_BLANKING_EN
    typedef enum logic {
        SCAN,
        BLANK
    } state_t;

    state_t state_q, state_d;
`endif

    logic          run_q, run_d;
    logic [34:0]   disp_q, disp_d;
    logic [34:0]   shadow_q, shadow_d;
    logic          full_q, full_d;
    logic [DW-1:0] dwell_q, dwell_d;
    logic [2:0]    row_q, row_d;
    logic [4:0]    en_q, en_d;
    logic          fs_q, fs_d;
    logic          rdy_q, rdy_d;
    logic          wrap;

    assign frame_ready    = rdy_q;
    assign rows_values    = disp_q;
    assign bin_number_sel = row_q;
    assign row_enable     = en_q;
    assign frame_start    = fs_q;

    // Next-state: dwell/row sequencing, buffer swap at the frame wrap, shadow capture
    always_comb begin
        run_d    = 1'b1;
        disp_d   = disp_q;
        shadow_d = shadow_q;
        full_d   = full_q;
        dwell_d  = dwell_q;
        row_d    = row_q;
        en_d     = en_q;
        fs_d     = 1'b0;
        wrap     = 1'b0;
`ifdef SCANNER_BLANKING_EN
        state_d  = state_q;
`endif
        if (!run_q) begin
            dwell_d = '0;
            row_d   = 3'd0;
            en_d    = 5'b00001;
            fs_d    = 1'b1;
`ifdef SCANNER_BLANKING_EN
            state_d = SCAN;
        end else if (state_q == BLANK) begin
            en_d = 5'b00000;
            if (dwell_q == DW'(BLANK_CYCLES - 1)) begin
                state_d = SCAN;
                dwell_d = '0;
                en_d    = 5'b00001 << row_q;
                fs_d    = (row_q == 3'd0);
            end else begin
                dwell_d = dwell_q + 1'b1;
            end
`endif
        end else if (dwell_q == DW'(CLK_DIV - 1)) begin
            wrap    = (row_q == 3'd4);
            row_d   = wrap ? 3'd0 : row_q + 3'd1;
            dwell_d = '0;
`ifdef SCANNER_BLANKING_EN
            state_d = BLANK;
            en_d    = 5'b00000;
`else
            en_d    = 5'b00001 << row_d;
            fs_d    = wrap;
`endif
        end else begin
            dwell_d = dwell_q + 1'b1;
            en_d    = 5'b00001 << row_q;
        end

        if (wrap && full_q) begin
            disp_d = shadow_q;
            full_d = 1'b0;
        end else if (frame_valid && rdy_q) begin
            shadow_d = frame_data;
            full_d   = 1'b1;
        end
        rdy_d = ~full_d;
    end

    // State register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            run_q    <= 1'b0;
            disp_q   <= '0;
            shadow_q <= '0;
            full_q   <= 1'b0;
            dwell_q  <= '0;
            row_q    <= 3'd0;
            en_q     <= 5'b00000;
            fs_q     <= 1'b0;
            rdy_q    <= 1'b0;
`ifdef SCANNER_BLANKING_EN
            state_q  <= SCAN;
`endif
        end else begin
            run_q    <= run_d;
            disp_q   <= disp_d;
            shadow_q <= shadow_d;
            full_q   <= full_d;
            dwell_q  <= dwell_d;
            row_q    <= row_d;
            en_q     <= en_d;
            fs_q     <= fs_d;
            rdy_q    <= rdy_d;
`ifdef SCANNER_BLANKING_EN
            state_q  <= state_d;
`endif
        end
    end

endmodule
